// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register bank with two prioritised write ports
// (wr1 over wr0), NRD registered read ports and a per-register busy
// scoreboard for read-after-write hazard detection by the issue stage.
// Optional macro REGFILE_BYPASS_EN: when defined, reads sampled at an edge
// see that edge's writes and scoreboard updates; otherwise reads see the
// state from before the edge.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic [AW:0]         busy_cnt
);

  localparam int NREGS = 2**AW;

  logic [XLEN-1:0]     regs [NREGS];
  logic [NREGS-1:0]    busy;
  logic [NREGS-1:0]    busy_nxt;
  logic                wr0_ok;
  logic                wr1_ok;
  logic                iss_ok;
  logic [NRD*XLEN-1:0] rd_data_nxt;
  logic [NRD-1:0]      rd_busy_nxt;

  // Number of set bits in the busy vector; cannot exceed NREGS-1 since bit 0 is never set.
  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + {{AW{1'b0}}, v[i]};
    return c;
  endfunction

  // Register 0 is hardwired: writes and issues targeting it are dropped.
  assign wr0_ok = wr0_en && (wr0_addr != '0);
  assign wr1_ok = wr1_en && (wr1_addr != '0);
  assign iss_ok = iss_en && (iss_rd != '0);

  // Scoreboard update: writes retire the producer, a same-edge issue re-claims the register.
  always_comb begin
    busy_nxt = busy;
    if (wr0_ok) busy_nxt[wr0_addr] = 1'b0;
    if (wr1_ok) busy_nxt[wr1_addr] = 1'b0;
    if (iss_ok) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Read-port selection; address 0 always yields zero data and not-busy.
  always_comb begin
    rd_data_nxt = '0;
    rd_busy_nxt = '0;
    for (int k = 0; k < NRD; k++) begin
      if (rd_addr[k*AW +: AW] != '0) begin
`ifdef REGFILE_BYPASS_EN
        if (wr1_ok && (wr1_addr == rd_addr[k*AW +: AW]))
          rd_data_nxt[k*XLEN +: XLEN] = wr1_data;
        else if (wr0_ok && (wr0_addr == rd_addr[k*AW +: AW]))
          rd_data_nxt[k*XLEN +: XLEN] = wr0_data;
        else
          rd_data_nxt[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
        rd_busy_nxt[k] = busy_nxt[rd_addr[k*AW +: AW]];
`else
        rd_data_nxt[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
        rd_busy_nxt[k] = busy[rd_addr[k*AW +: AW]];
`endif
      end
    end
  end

  // Register storage; wr1 is applied last so it overrides wr0 on the same address.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wr0_ok) regs[wr0_addr] <= wr0_data;
      if (wr1_ok) regs[wr1_addr] <= wr1_data;
    end
  end

  // Scoreboard state, busy count and registered read outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
      rd_data  <= '0;
      rd_busy  <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
      rd_data  <= rd_data_nxt;
      rd_busy  <= rd_busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against an
// array-based reference model of the register bank and scoreboard.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NREGS = 32;

  logic                clock = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr0_en;
  logic [AW-1:0]       wr0_addr;
  logic [XLEN-1:0]     wr0_data;
  logic                wr1_en;
  logic [AW-1:0]       wr1_addr;
  logic [XLEN-1:0]     wr1_data;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic [AW:0]         busy_cnt;

  logic [AW-1:0]       ra [NRD];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [XLEN-1:0] mem [NREGS];
  bit              bsy [NREGS];

  always #5 clock = ~clock;

  always_comb begin
    for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = ra[k];
  end

  regfile_sb #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) dut (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .busy_cnt (busy_cnt)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset    = 1'b0;
    wr0_en   = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en   = 1'b0; wr1_addr = '0; wr1_data = '0;
    iss_en   = 1'b0; iss_rd   = '0;
    for (int k = 0; k < NRD; k++) ra[k] = '0;
  endtask

  // One clock: predict outputs from current inputs and model, step, compare.
  task automatic cycle(input string tag);
    logic [XLEN-1:0] nmem [NREGS];
    bit              nbsy [NREGS];
    logic [XLEN-1:0] ed [NRD];
    logic            eb [NRD];
    int              ecnt;
    nmem = mem;
    nbsy = bsy;
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin nmem[i] = '0; nbsy[i] = 1'b0; end
    end else begin
      if (wr0_en && wr0_addr != 0) begin nmem[wr0_addr] = wr0_data; nbsy[wr0_addr] = 1'b0; end
      if (wr1_en && wr1_addr != 0) begin nmem[wr1_addr] = wr1_data; nbsy[wr1_addr] = 1'b0; end
      if (iss_en && iss_rd != 0) nbsy[iss_rd] = 1'b1;
    end
    for (int k = 0; k < NRD; k++) begin
      if (reset || ra[k] == 0) begin
        ed[k] = '0; eb[k] = 1'b0;
      end else begin
`ifdef REGFILE_BYPASS_EN
        ed[k] = nmem[ra[k]]; eb[k] = nbsy[ra[k]];
`else
        ed[k] = mem[ra[k]];  eb[k] = bsy[ra[k]];
`endif
      end
    end
    ecnt = 0;
    for (int i = 0; i < NREGS; i++) ecnt += int'(nbsy[i]);
    @(posedge clock);
    #1;
    mem = nmem;
    bsy = nbsy;
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("%s rd_data%0d", tag, k), rd_data[k*XLEN +: XLEN], ed[k]);
      check($sformatf("%s rd_busy%0d", tag, k), {31'b0, rd_busy[k]}, {31'b0, eb[k]});
    end
    check($sformatf("%s busy_cnt", tag), {26'b0, busy_cnt}, ecnt[XLEN-1:0]);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin mem[i] = '0; bsy[i] = 1'b0; end

    // Reset then read every register on both ports
    idle();
    reset = 1'b1;
    cycle("reset");
    check("reset busy_cnt const", {26'b0, busy_cnt}, 32'd0);
    idle();
    for (int a = 1; a < NREGS; a++) begin
      ra[0] = AW'(a); ra[1] = AW'(NREGS - a);
      cycle("post_reset_read");
    end

    // x0 protection
    idle();
    wr0_en = 1'b1; wr0_addr = '0; wr0_data = 32'hDEADBEEF;
    iss_en = 1'b1; iss_rd = '0;
    cycle("x0_write");
    idle();
    cycle("x0_read");
    check("x0 rd_data const", rd_data[XLEN-1:0], 32'h0);
    check("x0 busy_cnt const", {26'b0, busy_cnt}, 32'd0);

    // Dual-write conflict on address 5
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h11111111;
    wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h22222222;
    cycle("dual_wr");
    idle();
    ra[0] = 5'd5;
    cycle("dual_rd");
    check("dual_wr const", rd_data[XLEN-1:0], 32'h22222222);

    // Scoreboard sequence on register 7
    idle();
    iss_en = 1'b1; iss_rd = 5'd7;
    cycle("sb_iss");
    check("sb_iss busy_cnt const", {26'b0, busy_cnt}, 32'd1);
    idle();
    ra[1] = 5'd7;
    cycle("sb_look");
    check("sb_look rd_busy const", {31'b0, rd_busy[1]}, 32'd1);
    idle();
    iss_en = 1'b1; iss_rd = 5'd7;
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hA5;
    ra[1] = 5'd7;
    cycle("sb_iss_wr");
    check("sb_iss_wr busy_cnt const", {26'b0, busy_cnt}, 32'd1);
    idle();
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h5A;
    cycle("sb_clear");
    check("sb_clear busy_cnt const", {26'b0, busy_cnt}, 32'd0);
    idle();
    ra[0] = 5'd7;
    cycle("sb_read");
    check("sb_read data const", rd_data[XLEN-1:0], 32'h5A);
    check("sb_read busy const", {31'b0, rd_busy[0]}, 32'd0);

    // Same-edge read/write collision on address 3
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h1234;
    ra[0] = 5'd3;
    cycle("collide");
`ifdef REGFILE_BYPASS_EN
    check("collide const", rd_data[XLEN-1:0], 32'h1234);
`else
    check("collide const", rd_data[XLEN-1:0], 32'h0);
`endif
    idle();
    ra[0] = 5'd3;
    cycle("collide_next");
    check("collide_next const", rd_data[XLEN-1:0], 32'h1234);

    // Reset mid-operation
    for (int a = 1; a <= 4; a++) begin
      idle();
      wr0_en = 1'b1; wr0_addr = AW'(a); wr0_data = 32'h100 + a;
      if (a == 4) begin iss_en = 1'b1; iss_rd = 5'd3; end
      cycle("pre_rst_wr");
    end
    idle();
    reset = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h77;
    ra[0] = 5'd3; ra[1] = 5'd1;
    cycle("mid_reset");
    check("mid_reset busy_cnt const", {26'b0, busy_cnt}, 32'd0);
    idle();
    ra[0] = 5'd9; ra[1] = 5'd3;
    cycle("after_reset");
    check("after_reset r9 const", rd_data[XLEN-1:0], 32'h0);
    check("after_reset r3 const", rd_data[2*XLEN-1:XLEN], 32'h0);

    // Randomized traffic with biased address collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      reset    = ($urandom_range(0, 59) == 0);
      wr0_en   = $urandom_range(0, 1);
      wr0_addr = $urandom_range(0, 1) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
      wr0_data = $urandom;
      wr1_en   = $urandom_range(0, 2) == 0;
      wr1_addr = $urandom_range(0, 1) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
      wr1_data = $urandom;
      iss_en   = $urandom_range(0, 1);
      iss_rd   = $urandom_range(0, 1) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
      for (int k = 0; k < NRD; k++)
        ra[k] = $urandom_range(0, 1) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the single-write, two-read CPU register bank. It provides configurable width, register count and read-port count, and two write ports with fixed priority. A per-register busy scoreboard lets the issue stage detect read-after-write hazards, and optional write-to-read bypass can be compiled in. It sits between decode/issue (read and issue ports) and writeback (two write ports: ALU result and load return).

## Interface
- XLEN, 32, data width of each register.
- AW, 5, register address width; NREGS = 2**AW registers, index 0 hardwired to zero.
- NRD, 2, number of read ports (1..4).
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  registered read data, port k at [k*XLEN +: XLEN].
- rd_busy  out  NRD  registered busy flag of the addressed register, per port.
- wr0_en / wr0_addr / wr0_data  in  1 / AW / XLEN  write port 0 (ALU writeback).
- wr1_en / wr1_addr / wr1_data  in  1 / AW / XLEN  write port 1 (load writeback); it has priority over port 0.
- iss_en / iss_rd  in  1 / AW  issue: mark destination iss_rd busy.
- busy_cnt  out  AW+1  registered count of busy registers.

## Operation
- Storage: registers 1..NREGS-1 hold XLEN bits. Register 0 is never written, always reads 0 and is never busy.
- Writes: wrN_en with wrN_addr != 0 updates the register at the edge. If both ports target the same non-zero address in the same cycle, wr1_data is stored.
- Busy clear: every accepted write (port 0 or 1, address != 0) clears the busy bit of its address.
- Busy set: iss_en with iss_rd != 0 sets busy[iss_rd].
  - If it coincides with a write to the same address, the set wins: the new producer owns the register.
  - iss_en on an already-busy register leaves it busy; this is not an error.
- Reads: each port samples rd_addr every edge; no enable. rd_data is 0 and rd_busy is 0 whenever the sampled address is 0.
- busy_cnt: the population count of the busy vector after the edge's updates, registered. Range 0..NREGS-1; it never wraps.
- Reset (any cycle, including mid-operation): all registers, busy bits, rd_data, rd_busy and busy_cnt go to 0. Writes and issues presented in the reset cycle are discarded.

## Timing
- Read latency is 1 cycle: rd_addr sampled at edge N gives rd_data/rd_busy valid from edge N until edge N+1.
- Write latency is 1 cycle: data presented at edge N is stored at edge N.
- Same-edge read/write collision resolves per REGFILE_BYPASS_EN (see Configuration).
- busy_cnt reflects issues and writes at edge N from edge N onward, in both configurations.
- No handshakes: every input is consumed every cycle. There are no stalls and no back-pressure.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined:
  - rd_data at edge N includes writes accepted at edge N to the same address, with wr1 over wr0.
  - rd_busy at edge N reflects the post-update busy state: set by iss at N, cleared by a write at N, and set wins.
  - Decode sees results one cycle earlier.
- Undefined:
  - rd_data and rd_busy at edge N reflect the state before edge N's updates, matching the previous-generation bank.
  - A write at N becomes visible to reads sampled at edge N+1.
- Register 0 behaviour, reset behaviour and busy_cnt are identical in both builds.

## Test plan
- Reset then read: assert reset 1 cycle, read addrs 1..31 on both ports -> every rd_data = 0, rd_busy = 0, busy_cnt = 0.
- x0 protection: wr0 to addr 0 with 0xDEADBEEF and iss_en to addr 0 -> read addr 0 gives 0, rd_busy = 0, busy_cnt unchanged.
- Dual-write conflict: same cycle wr0 (addr 5, 0x11111111) and wr1 (addr 5, 0x22222222) -> next-cycle read of addr 5 = 0x22222222.
- Scoreboard:
  - iss 7 -> busy_cnt = 1 and rd_busy on addr 7.
  - Then iss 7 together with wr0 to 7 = 0xA5 -> busy stays set, busy_cnt = 1.
  - Then wr1 to 7 = 0x5A alone -> busy clear, busy_cnt = 0, read = 0x5A.
- Collision: read addr 3 while wr0 writes 3 = 0x1234 (old value 0) -> rd_data = 0x1234 with REGFILE_BYPASS_EN, 0 without it; the following cycle gives 0x1234 in both builds.
- Reset mid-operation: with registers 1..4 written and 3 busy, assert reset in the same cycle as wr0 to addr 9 = 0x77 -> all reads 0, busy_cnt 0, addr 9 reads 0 after reset deasserts.
